// File: rtl/button_event_queue_if.sv
// ----------------------------------------------------------------------------
// button_event_queue_if
// Purpose : valid/ready event channel between the button event queue and the
//           game controller.
// Signals :
//   ev_valid  queue is non-empty (driven by master)
//   ev_code   2-bit colour code of the head event (driven by master)
//   ev_ready  consumer accepts the head event (driven by slave)
// Modports:
//   master  event source (button_event_queue)
//   slave   event consumer (game controller)
// ----------------------------------------------------------------------------
interface button_event_queue_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_code;

  modport master (
    output ev_valid,
    output ev_code,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_code,
    output ev_ready
  );
endinterface

// File: rtl/button_event_queue.sv
// ----------------------------------------------------------------------------
// button_event_queue
// Purpose : turns clean single-button presses from four debounced button
//           levels into 2-bit colour events, queues up to two of them behind
//           a valid/ready handshake, rejects multi-button presses, drives
//           press-feedback LEDs and optionally flags player inactivity.
// Parameters:
//   TIMEOUT_W    width of the inactivity counter
//   TIMEOUT_MAX  idle cycles allowed in S_WAIT before timeout (1..2^W-1)
// Ports:
//   clk        system clock
//   n_reset    asynchronous active-low reset
//   btn[3:0]   debounced button levels, bit i is colour i
//   arm        player turn active; low returns to idle and flushes the queue
//   ev         event channel (master modport: ev_valid, ev_code out,
//              ev_ready in)
//   press_led  one-hot copy of the accepted held button
//   overflow   one-cycle pulse when a press is dropped on a full queue
//   timeout    one-cycle inactivity pulse
// Configuration macro:
//   BEQ_TIMEOUT_EN  when defined, compiles in the inactivity counter and the
//                   S_EXPIRED state; otherwise timeout is tied low and S_WAIT
//                   waits indefinitely.
// ----------------------------------------------------------------------------
module button_event_queue #(
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_MAX = 50000
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic [3:0]           btn,
  input  logic                 arm,
  button_event_queue_if.master ev,
  output logic [3:0]           press_led,
  output logic                 overflow,
  output logic                 timeout
);

  // Reject illegal parameter combinations at elaboration time.
  generate
    if ((TIMEOUT_W < 1) || (TIMEOUT_W > 62) || (TIMEOUT_MAX < 1) ||
        (longint'(TIMEOUT_MAX) > ((64'sd1 <<< TIMEOUT_W) - 64'sd1))) begin : g_bad_cfg
      $error("button_event_queue: TIMEOUT_MAX out of range for TIMEOUT_W");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_HELD    = 3'd2,
    S_MULTI   = 3'd3
`ifdef BEQ_TIMEOUT_EN
    ,S_EXPIRED = 3'd4
`endif
  } state_t;

  // True when exactly one bit of the button vector is set.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Index of the set bit of a one-hot vector.
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  state_t     state_r;
  logic [3:0] press_led_r;

`ifdef BEQ_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_MAX - 1);
  logic [TIMEOUT_W-1:0] cnt_r;
  logic                 timeout_r;
`endif

  // Queue storage: head_r is always the oldest entry, tail_r the second.
  logic [1:0] head_r;
  logic [1:0] tail_r;
  logic [1:0] count_r;
  logic       ev_valid_r;
  logic       overflow_r;

  logic       btn_none_s;
  logic       btn_one_s;
  logic [1:0] btn_idx_s;
  logic       push_s;
  logic       pop_s;
  logic [1:0] head_nxt_s;
  logic [1:0] tail_nxt_s;
  logic [1:0] count_nxt_s;
  logic       overflow_nxt_s;

  assign btn_none_s = (btn == 4'd0);
  assign btn_one_s  = is_onehot(btn);
  assign btn_idx_s  = onehot_index(btn);

  // A push is the S_WAIT -> S_HELD transition; a pop is the accepted head.
  assign push_s = arm && (state_r == S_WAIT) && btn_one_s;
  assign pop_s  = ev_valid_r && ev.ev_ready;

  // Press-capture FSM with registered LED and timeout outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r     <= S_IDLE;
      press_led_r <= 4'd0;
`ifdef BEQ_TIMEOUT_EN
      cnt_r       <= '0;
      timeout_r   <= 1'b0;
`endif
    end else begin
`ifdef BEQ_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      if (!arm) begin
        state_r     <= S_IDLE;
        press_led_r <= 4'd0;
      end else begin
        case (state_r)
          S_IDLE: begin
            // A press is only accepted after every button has been released.
            if (btn_none_s) begin
              state_r <= S_WAIT;
`ifdef BEQ_TIMEOUT_EN
              cnt_r   <= '0;
`endif
            end else begin
              state_r <= S_MULTI;
            end
          end
          S_WAIT: begin
            if (btn_one_s) begin
              state_r     <= S_HELD;
              press_led_r <= btn;
            end else if (!btn_none_s) begin
              state_r <= S_MULTI;
`ifdef BEQ_TIMEOUT_EN
            end else if (cnt_r == CNT_LAST) begin
              state_r   <= S_EXPIRED;
              timeout_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
`else
            end else begin
              state_r <= S_WAIT;
`endif
            end
          end
          S_HELD: begin
            // Extra buttons pressed while holding are ignored.
            if (btn_none_s) begin
              state_r     <= S_WAIT;
              press_led_r <= 4'd0;
`ifdef BEQ_TIMEOUT_EN
              cnt_r       <= '0;
`endif
            end else begin
              state_r <= S_HELD;
            end
          end
          S_MULTI: begin
            if (btn_none_s) begin
              state_r <= S_WAIT;
`ifdef BEQ_TIMEOUT_EN
              cnt_r   <= '0;
`endif
            end else begin
              state_r <= S_MULTI;
            end
          end
`ifdef BEQ_TIMEOUT_EN
          S_EXPIRED: begin
            // Only arm going low leaves this state.
            state_r <= S_EXPIRED;
          end
`endif
          default: begin
            state_r     <= S_IDLE;
            press_led_r <= 4'd0;
          end
        endcase
      end
    end
  end

  // Next-state logic of the two-entry queue; flush wins over push and pop.
  always_comb begin
    head_nxt_s     = head_r;
    tail_nxt_s     = tail_r;
    count_nxt_s    = count_r;
    overflow_nxt_s = 1'b0;
    if (!arm) begin
      count_nxt_s = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          case (count_r)
            2'd0: begin
              head_nxt_s  = btn_idx_s;
              count_nxt_s = 2'd1;
            end
            2'd1: begin
              tail_nxt_s  = btn_idx_s;
              count_nxt_s = 2'd2;
            end
            default: begin
              // Full with no pop: drop the event, contents unchanged.
              overflow_nxt_s = 1'b1;
            end
          endcase
        end
        2'b01: begin
          // Head is left untouched when emptying so ev_code holds.
          if (count_r == 2'd2) begin
            head_nxt_s = tail_r;
          end else begin
            head_nxt_s = head_r;
          end
          count_nxt_s = count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            head_nxt_s = btn_idx_s;
          end else begin
            head_nxt_s = tail_r;
            tail_nxt_s = btn_idx_s;
          end
        end
        default: begin
          count_nxt_s = count_r;
        end
      endcase
    end
  end

  // Queue registers and registered handshake/overflow outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      head_r     <= 2'd0;
      tail_r     <= 2'd0;
      count_r    <= 2'd0;
      ev_valid_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      head_r     <= head_nxt_s;
      tail_r     <= tail_nxt_s;
      count_r    <= count_nxt_s;
      ev_valid_r <= (count_nxt_s != 2'd0);
      overflow_r <= overflow_nxt_s;
    end
  end

  assign ev.ev_valid = ev_valid_r;
  assign ev.ev_code  = head_r;
  assign press_led   = press_led_r;
  assign overflow    = overflow_r;
`ifdef BEQ_TIMEOUT_EN
  assign timeout     = timeout_r;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_queue.sv
// ----------------------------------------------------------------------------
// tb_button_event_queue
// Self-checking bench for button_event_queue. Expected colour codes are
// pushed to a scoreboard queue when a press is driven and popped when the
// DUT presents an accepted event. Built with TIMEOUT_MAX = 8; the timeout
// scenario depends on whether BEQ_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module tb_button_event_queue;
  logic       clk = 1'b0;
  logic       n_reset;
  logic       arm;
  logic [3:0] btn;
  logic [3:0] press_led;
  logic       overflow;
  logic       timeout;

  button_event_queue_if ev_if();

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_code;

  always #5 clk = ~clk;

  button_event_queue #(
    .TIMEOUT_W   (16),
    .TIMEOUT_MAX (8)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .btn       (btn),
    .arm       (arm),
    .ev        (ev_if),
    .press_led (press_led),
    .overflow  (overflow),
    .timeout   (timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tap(input logic [3:0] b);
    btn = b;
    step();
    btn = 4'd0;
    step();
  endtask

  task automatic test_reset();
    n_reset = 1'b1; arm = 1'b0; btn = 4'd0; ev_if.ev_ready = 1'b0;
    #2 n_reset = 1'b0;
    #1;
    n_checks++;
    if ({ev_if.ev_valid, ev_if.ev_code, press_led, overflow, timeout} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 000000000",
               {ev_if.ev_valid, ev_if.ev_code, press_led, overflow, timeout});
    end
    step();
    n_reset = 1'b1;
    step();
  endtask

  task automatic test_single_press();
    int n_ev = 0;
    arm = 1'b1; btn = 4'd0; ev_if.ev_ready = 1'b1;
    step(); step();
    btn = 4'b0100;
    exp_q.push_back(2'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (press_led !== 4'b0100) begin
        n_fail++;
        $display("FAIL single_led: got %b want 0100", press_led);
      end
      if (ev_if.ev_valid === 1'b1) begin
        n_ev++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL single_extra_event: got code %0d want none", ev_if.ev_code);
        end else begin
          exp_code = exp_q.pop_front();
          if (ev_if.ev_code !== exp_code) begin
            n_fail++;
            $display("FAIL single_code: got %0d want %0d", ev_if.ev_code, exp_code);
          end
        end
      end
    end
    btn = 4'd0;
    step();
    n_checks++;
    if ((press_led !== 4'd0) || (n_ev != 1) || (ev_if.ev_valid !== 1'b0)) begin
      n_fail++;
      $display("FAIL single_release: led %b events %0d valid %b want 0000 1 0",
               press_led, n_ev, ev_if.ev_valid);
    end
  endtask

  task automatic test_multi_press();
    ev_if.ev_ready = 1'b1;
    btn = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ((ev_if.ev_valid !== 1'b0) || (press_led !== 4'd0)) begin
        n_fail++;
        $display("FAIL multi_reject: valid %b led %b want 0 0000", ev_if.ev_valid, press_led);
      end
    end
    btn = 4'd0;
    step();
    btn = 4'b0001;
    exp_q.push_back(2'd0);
    step();
    n_checks++;
    exp_code = exp_q.pop_front();
    if ((ev_if.ev_valid !== 1'b1) || (ev_if.ev_code !== exp_code) || (press_led !== 4'b0001)) begin
      n_fail++;
      $display("FAIL multi_then_single: valid %b code %0d led %b want 1 %0d 0001",
               ev_if.ev_valid, ev_if.ev_code, press_led, exp_code);
    end
    step();
    n_checks++;
    if (ev_if.ev_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_popped: valid %b want 0", ev_if.ev_valid);
    end
    btn = 4'd0;
    step();
  endtask

  task automatic test_overflow();
    int n_ev = 0;
    int n_ovf = 0;
    ev_if.ev_ready = 1'b0;
    btn = 4'b0010; exp_q.push_back(2'd1); step(); if (overflow === 1'b1) n_ovf++;
    btn = 4'd0;    step(); if (overflow === 1'b1) n_ovf++;
    btn = 4'b0100; exp_q.push_back(2'd2); step(); if (overflow === 1'b1) n_ovf++;
    btn = 4'd0;    step(); if (overflow === 1'b1) n_ovf++;
    btn = 4'b1000;
    step();
    n_checks++;
    if ((overflow !== 1'b1) || (n_ovf != 0)) begin
      n_fail++;
      $display("FAIL overflow_pulse: got %b (early pulses %0d) want 1 (0)", overflow, n_ovf);
    end
    btn = 4'd0;
    step();
    n_checks++;
    if ((overflow !== 1'b0) || (ev_if.ev_valid !== 1'b1) || (ev_if.ev_code !== 2'd1)) begin
      n_fail++;
      $display("FAIL overflow_after: ovf %b valid %b code %0d want 0 1 1",
               overflow, ev_if.ev_valid, ev_if.ev_code);
    end
    ev_if.ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (ev_if.ev_valid === 1'b1) begin
        n_ev++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL overflow_extra_event: got code %0d want none", ev_if.ev_code);
        end else begin
          exp_code = exp_q.pop_front();
          if (ev_if.ev_code !== exp_code) begin
            n_fail++;
            $display("FAIL overflow_drain_code: got %0d want %0d", ev_if.ev_code, exp_code);
          end
        end
      end
      step();
    end
    n_checks++;
    if ((n_ev != 2) || (ev_if.ev_valid !== 1'b0)) begin
      n_fail++;
      $display("FAIL overflow_drain_count: events %0d valid %b want 2 0", n_ev, ev_if.ev_valid);
    end
  endtask

  task automatic test_push_pop_full();
    ev_if.ev_ready = 1'b0;
    exp_q.push_back(2'd1); tap(4'b0010);
    exp_q.push_back(2'd2); tap(4'b0100);
    btn = 4'b1000;
    ev_if.ev_ready = 1'b1;
    exp_q.push_back(2'd3);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      exp_code = exp_q.pop_front();
      if ((ev_if.ev_valid !== 1'b1) || (ev_if.ev_code !== exp_code)) begin
        n_fail++;
        $display("FAIL pushpop_head%0d: valid %b code %0d want 1 %0d",
                 i, ev_if.ev_valid, ev_if.ev_code, exp_code);
      end
      step();
      if (i == 0) begin
        n_checks++;
        if (overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL pushpop_overflow: got %b want 0", overflow);
        end
      end
    end
    n_checks++;
    if (ev_if.ev_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pushpop_empty: valid %b want 0", ev_if.ev_valid);
    end
    btn = 4'd0;
    step();
  endtask

  task automatic test_arm_flush();
    ev_if.ev_ready = 1'b0;
    tap(4'b0010);
    tap(4'b0001);
    arm = 1'b0;
    step();
    n_checks++;
    if ((ev_if.ev_valid !== 1'b0) || (ev_if.ev_code !== 2'd1)) begin
      n_fail++;
      $display("FAIL arm_flush: valid %b code %0d want 0 1", ev_if.ev_valid, ev_if.ev_code);
    end
    arm = 1'b1;
    step(); step();
    n_checks++;
    if (ev_if.ev_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arm_rearm_empty: valid %b want 0", ev_if.ev_valid);
    end
  endtask

  task automatic test_reset_mid();
    ev_if.ev_ready = 1'b0;
    tap(4'b0001);
    btn = 4'b0010;
    step();
    n_checks++;
    if ((ev_if.ev_valid !== 1'b1) || (press_led !== 4'b0010)) begin
      n_fail++;
      $display("FAIL midreset_setup: valid %b led %b want 1 0010", ev_if.ev_valid, press_led);
    end
    #2 n_reset = 1'b0;
    #1;
    n_checks++;
    if ({ev_if.ev_valid, ev_if.ev_code, press_led, overflow, timeout} !== 9'd0) begin
      n_fail++;
      $display("FAIL midreset_async: got %b want 000000000",
               {ev_if.ev_valid, ev_if.ev_code, press_led, overflow, timeout});
    end
    step();
    n_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ((ev_if.ev_valid !== 1'b0) || (press_led !== 4'd0)) begin
        n_fail++;
        $display("FAIL midreset_held_ignored: valid %b led %b want 0 0000", ev_if.ev_valid, press_led);
      end
    end
    btn = 4'd0;
    step(); step();
    btn = 4'b1000;
    exp_q.push_back(2'd3);
    step();
    n_checks++;
    exp_code = exp_q.pop_front();
    if ((ev_if.ev_valid !== 1'b1) || (ev_if.ev_code !== exp_code) || (press_led !== 4'b1000)) begin
      n_fail++;
      $display("FAIL midreset_recover: valid %b code %0d led %b want 1 %0d 1000",
               ev_if.ev_valid, ev_if.ev_code, press_led, exp_code);
    end
    ev_if.ev_ready = 1'b1;
    step();
    btn = 4'd0;
    step();
  endtask

  task automatic test_timeout();
    arm = 1'b0; btn = 4'd0; ev_if.ev_ready = 1'b1;
    step();
    arm = 1'b1;
    step();
`ifdef BEQ_TIMEOUT_EN
    for (int k = 1; k <= 9; k++) begin
      step();
      n_checks++;
      if (timeout !== ((k == 8) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL timeout_cycle%0d: got %b want %b", k, timeout, (k == 8) ? 1'b1 : 1'b0);
      end
    end
    btn = 4'b0001;
    step();
    btn = 4'd0;
    step();
    n_checks++;
    if ((ev_if.ev_valid !== 1'b0) || (press_led !== 4'd0)) begin
      n_fail++;
      $display("FAIL timeout_expired_press: valid %b led %b want 0 0000", ev_if.ev_valid, press_led);
    end
    arm = 1'b0;
    step();
    arm = 1'b1;
    step();
`else
    begin
      int n_to = 0;
      for (int k = 0; k < 30; k++) begin
        step();
        if (timeout !== 1'b0) n_to++;
      end
      n_checks++;
      if (n_to != 0) begin
        n_fail++;
        $display("FAIL timeout_disabled: got %0d pulses want 0", n_to);
      end
    end
`endif
    btn = 4'b0010;
    exp_q.push_back(2'd1);
    step();
    n_checks++;
    exp_code = exp_q.pop_front();
    if ((ev_if.ev_valid !== 1'b1) || (ev_if.ev_code !== exp_code)) begin
      n_fail++;
      $display("FAIL timeout_capture: valid %b code %0d want 1 %0d",
               ev_if.ev_valid, ev_if.ev_code, exp_code);
    end
    step();
    btn = 4'd0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_multi_press();
    test_overflow();
    test_push_pop_full();
    test_arm_flush();
    test_reset_mid();
    test_timeout();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
